// File: rtl/ysyx_idu_pkg.sv
// ysyx IDU shared definitions: opcodes, immediate formats,
// handshake states and the immediate generator.
package ysyx_idu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_WAIT
  } hs_state_e;

  typedef struct packed {
    logic op;
    logic op_imm;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic system;
  } opc_cls_t;

  function automatic logic [31:0] imm_gen(
    input imm_fmt_e    fmt,
    input logic [31:0] i
  );
    logic [31:0] r;
    r = '0;
    unique case (fmt)
      IMM_I: r = {{20{i[31]}}, i[31:20]};
      IMM_S: r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B: r = {{19{i[31]}}, i[31], i[7],
                  i[30:25], i[11:8], 1'b0};
      IMM_U: r = {i[31:12], 12'b0};
      IMM_J: r = {{11{i[31]}}, i[31], i[19:12],
                  i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ysyx_idu_scoreboard.sv
// Register busy-bit scoreboard; queries see the same-cycle
// writeback clear as a bypass, x0 is never busy.
module ysyx_idu_scoreboard #(
  parameter int REG_NUM = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic       flush,
  input  logic [4:0] q1_idx,
  output logic       q1_busy,
  input  logic [4:0] q2_idx,
  output logic       q2_busy
);

  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_eff;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (set_en && set_idx == 5'(i) && i != 0)
          busy_q[i] <= 1'b1;
        else if (clr_en && clr_idx == 5'(i))
          busy_q[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    busy_eff = busy_q;
    for (int i = 0; i < REG_NUM; i++) begin
      if (clr_en && clr_idx == 5'(i))
        busy_eff[i] = 1'b0;
    end
    busy_eff[0] = 1'b0;
  end

  always_comb begin
    q1_busy = 1'b0;
    q2_busy = 1'b0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (q1_idx == 5'(i))
        q1_busy = busy_eff[i];
      if (q2_idx == 5'(i))
        q2_busy = busy_eff[i];
    end
  end

endmodule

// File: rtl/ysyx_idu.sv
// ysyx instruction decode stage: one-entry pipeline register,
// RV32 field/immediate decode and RAW hazard interlock.
module ysyx_idu
  import ysyx_idu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic [DATA_W-1:0] inst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              next_ready,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        rd_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic              wen_o,
  output logic              is_load_o,
  output logic              is_store_o,
  output logic              is_branch_o,
  output logic              is_jal_o,
  output logic              is_jalr_o,
  output logic              is_system_o,
  output logic              illegal_o,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              flush
);

  localparam logic [5:0] RN = 6'(REG_NUM);

  logic              valid_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_q;

  logic [6:0] opc;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  opc_cls_t   cls;
  imm_fmt_e   fmt;
  logic       known;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       wr_cls;
  logic       bad_reg;
  logic       illegal;
  logic       wen;
  logic [DATA_W-1:0] imm;

  logic rs1_busy;
  logic rs2_busy;
  logic hz;
  logic accept;
  logic issue;

  assign opc = inst_q[6:0];
  assign rs1 = inst_q[19:15];
  assign rs2 = inst_q[24:20];
  assign rd  = inst_q[11:7];

  always_comb begin
    cls        = '0;
    cls.op     = opc == OPC_OP;
    cls.op_imm = opc == OPC_OP_IMM;
    cls.load   = opc == OPC_LOAD;
    cls.store  = opc == OPC_STORE;
    cls.branch = opc == OPC_BRANCH;
    cls.jal    = opc == OPC_JAL;
    cls.jalr   = opc == OPC_JALR;
    cls.lui    = opc == OPC_LUI;
    cls.auipc  = opc == OPC_AUIPC;
    cls.system = opc == OPC_SYSTEM;
  end

  always_comb begin
    fmt = IMM_NONE;
    unique case (1'b1)
      cls.op_imm, cls.load,
      cls.jalr, cls.system: fmt = IMM_I;
      cls.store:            fmt = IMM_S;
      cls.branch:           fmt = IMM_B;
      cls.lui, cls.auipc:   fmt = IMM_U;
      cls.jal:              fmt = IMM_J;
      default:              fmt = IMM_NONE;
    endcase
  end

  assign known = |cls;

  assign uses_rs1 = cls.op | cls.op_imm | cls.load
                  | cls.jalr | cls.system
                  | cls.store | cls.branch;
  assign uses_rs2 = cls.op | cls.store | cls.branch;
  assign wr_cls   = cls.op | cls.op_imm | cls.load
                  | cls.jalr | cls.lui | cls.auipc
                  | cls.jal;

  // Indices beyond the register file (RV32E) are undecodable.
  assign bad_reg = (uses_rs1 && {1'b0, rs1} >= RN)
                 | (uses_rs2 && {1'b0, rs2} >= RN)
                 | (wr_cls   && {1'b0, rd}  >= RN);

  assign illegal = !known
                 | (inst_q[1:0] != 2'b11)
                 | bad_reg;
  assign wen     = wr_cls & (rd != 5'd0) & !illegal;
  assign imm     = DATA_W'(imm_gen(fmt, 32'(inst_q)));

  ysyx_idu_scoreboard #(
    .REG_NUM(REG_NUM)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (issue & wen),
    .set_idx(rd),
    .clr_en (wb_valid),
    .clr_idx(wb_rd),
    .flush  (flush),
    .q1_idx (rs1),
    .q1_busy(rs1_busy),
    .q2_idx (rs2),
    .q2_busy(rs2_busy)
  );

  assign hz = valid_q
            & ((uses_rs1 & rs1_busy) | (uses_rs2 & rs2_busy));

  assign valid_o = valid_q & !hz & !flush;
  assign ready_o = !flush
                 & (!valid_q | (valid_o & next_ready));
  assign accept  = prev_valid & ready_o;
  assign issue   = valid_o & next_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      inst_q  <= inst;
      pc_q    <= pc;
    end else if (issue) begin
      valid_q <= 1'b0;
    end
  end

  // Decoded fields read as zero while the register is empty.
  assign pc_o        = valid_q ? pc_q : '0;
  assign rs1_o       = valid_q ? rs1 : '0;
  assign rs2_o       = valid_q ? rs2 : '0;
  assign rd_o        = valid_q ? rd : '0;
  assign imm_o       = valid_q ? imm : '0;
  assign opcode_o    = valid_q ? opc : '0;
  assign funct3_o    = valid_q ? inst_q[14:12] : '0;
  assign funct7_o    = valid_q ? inst_q[31:25] : '0;
  assign wen_o       = valid_q & wen;
  assign is_load_o   = valid_q & cls.load;
  assign is_store_o  = valid_q & cls.store;
  assign is_branch_o = valid_q & cls.branch;
  assign is_jal_o    = valid_q & cls.jal;
  assign is_jalr_o   = valid_q & cls.jalr;
  assign is_system_o = valid_q & cls.system;
  assign illegal_o   = valid_q & illegal;

endmodule

// File: tb/tb_ysyx_idu.sv
// Self-checking bench for ysyx_idu: vector table streamed through
// a scoreboard queue plus directed hazard/flush/reset sequences.
module tb_ysyx_idu;

  localparam logic [7:0] W  = 8'h80;
  localparam logic [7:0] LD = 8'h40;
  localparam logic [7:0] ST = 8'h20;
  localparam logic [7:0] BR = 8'h10;
  localparam logic [7:0] JL = 8'h08;
  localparam logic [7:0] JR = 8'h04;
  localparam logic [7:0] SY = 8'h02;
  localparam logic [7:0] IL = 8'h01;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [7:0]  fl;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [7:0]  fl;
  } vec_t;

  logic        clk = 0;
  logic        rst;
  logic        prev_valid;
  logic        ready_o;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        next_ready;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] imm_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic        wen_o;
  logic        is_load_o, is_store_o, is_branch_o;
  logic        is_jal_o, is_jalr_o, is_system_o;
  logic        illegal_o;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t q[$];
  int   iss[$];
  vec_t tbl[$];

  ysyx_idu #(
    .ADDR_W(32), .DATA_W(32), .REG_NUM(16)
  ) dut (
    .clk(clk), .rst(rst),
    .prev_valid(prev_valid), .ready_o(ready_o),
    .inst(inst), .pc(pc),
    .next_ready(next_ready), .valid_o(valid_o),
    .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .imm_o(imm_o), .opcode_o(opcode_o),
    .funct3_o(funct3_o), .funct7_o(funct7_o),
    .wen_o(wen_o), .is_load_o(is_load_o),
    .is_store_o(is_store_o), .is_branch_o(is_branch_o),
    .is_jal_o(is_jal_o), .is_jalr_o(is_jalr_o),
    .is_system_o(is_system_o), .illegal_o(illegal_o),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Scoreboard monitor: pops one expectation per issue.
  exp_t me, ma;
  always @(negedge clk) begin
    #2;
    if (rst && valid_o && next_ready) begin
      tests++;
      ma = {pc_o, rd_o, imm_o,
            {wen_o, is_load_o, is_store_o, is_branch_o,
             is_jal_o, is_jalr_o, is_system_o, illegal_o}};
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue got %h want none", ma);
      end else begin
        me = q.pop_front();
        if (ma !== me) begin
          fails++;
          $display("FAIL issue pc=%h got %h want %h",
                   pc_o, ma, me);
        end
      end
      iss.push_back(cyc);
    end
  end

  task automatic chk(string nm, logic [31:0] a, logic [31:0] w);
    tests++;
    if (a !== w) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, a, w);
    end
  endtask

  task automatic send(logic [31:0] i, logic [31:0] p,
                      logic [4:0] rd, logic [31:0] imm,
                      logic [7:0] fl);
    int n = 0;
    @(negedge clk);
    prev_valid = 1; inst = i; pc = p;
    #1;
    while (!ready_o && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!ready_o) begin
      tests++; fails++;
      $display("FAIL send_timeout got ready=0 want 1 pc=%h", p);
    end else begin
      q.push_back({p, rd, imm, fl});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    prev_valid = 0;
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk); #3; n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1;
    #1;
    chk("flush_ready", ready_o, 0);
    chk("flush_valid", valid_o, 0);
    q.delete();
    @(negedge clk);
    flush = 0;
    #1;
    chk("post_flush_valid", valid_o, 0);
    chk("post_flush_ready", ready_o, 1);
  endtask

  task automatic addv(logic [31:0] i, logic [4:0] rd,
                      logic [31:0] imm, logic [7:0] fl);
    vec_t v;
    v.inst = i; v.rd = rd; v.imm = imm; v.fl = fl;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 0; prev_valid = 0; inst = 0; pc = 0;
    next_ready = 1; wb_valid = 0; wb_rd = 0; flush = 0;

    addv(32'hFE208EE3, 5'd29, 32'hFFFFFFFC, BR);
    addv(32'h00500093, 5'd1,  32'h00000005, W);
    addv(32'hFFF00113, 5'd2,  32'hFFFFFFFF, W);
    addv(32'h00700193, 5'd3,  32'h00000007, W);
    addv(32'h001000EF, 5'd1,  32'h00000800, W | JL);
    addv(32'h12345237, 5'd4,  32'h12345000, W);
    addv(32'hFE002C23, 5'd24, 32'hFFFFFFF8, ST);
    addv(32'h00000000, 5'd0,  32'h00000000, IL);
    addv(32'h000008B3, 5'd17, 32'h00000000, IL);
    addv(32'h00001297, 5'd5,  32'h00001000, W);
    addv(32'hFF002303, 5'd6,  32'hFFFFFFF0, W | LD);
    addv(32'h004003E7, 5'd7,  32'h00000004, W | JR);
    addv(32'h34001473, 5'd8,  32'h00000340, SY);
    addv(32'h00500090, 5'd1,  32'h00000000, IL);
    addv(32'h00100013, 5'd0,  32'h00000001, 8'h00);
    addv(32'h80000793, 5'd15, 32'hFFFFF800, W);

    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_pc", pc_o, 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_wen", wen_o, 0);

    // Independent stream: one issue per cycle.
    iss.delete();
    foreach (tbl[k])
      send(tbl[k].inst, 32'h80000000 + 32'(k * 4),
           tbl[k].rd, tbl[k].imm, tbl[k].fl);
    idle();
    drain();
    chk("issue_count", iss.size(), tbl.size());
    if (iss.size() == tbl.size())
      chk("throughput", iss[iss.size()-1] - iss[0],
          tbl.size() - 1);

    do_flush();

    // RAW stall on x1 released by same-cycle writeback bypass.
    send(32'h00100093, 32'h100, 5'd1, 32'd1, W);
    send(32'h00108133, 32'h104, 5'd2, 32'd0, W);
    idle();
    chk("raw_stall_valid", valid_o, 0);
    chk("raw_stall_ready", ready_o, 0);
    @(negedge clk); #1;
    chk("raw_stall_valid2", valid_o, 0);
    @(negedge clk);
    wb_valid = 1; wb_rd = 5'd1;
    #1;
    chk("bypass_valid", valid_o, 1);
    @(negedge clk);
    wb_valid = 0;
    drain();

    // Issue of lw x5 with writeback of x5: set wins.
    next_ready = 0;
    send(32'h00032283, 32'h200, 5'd5, 32'd0, W | LD);
    idle();
    chk("hold_valid", valid_o, 1);
    chk("hold_ready", ready_o, 0);
    chk("hold_pc", pc_o, 32'h200);
    @(negedge clk);
    next_ready = 1; wb_valid = 1; wb_rd = 5'd5;
    #1;
    chk("lw_issue", valid_o, 1);
    @(negedge clk);
    wb_valid = 0;
    send(32'h00028433, 32'h204, 5'd8, 32'd0, W);
    idle();
    chk("set_wins_stall", valid_o, 0);
    @(negedge clk);
    wb_valid = 1; wb_rd = 5'd5;
    #1;
    chk("set_wins_release", valid_o, 1);
    @(negedge clk);
    wb_valid = 0;
    drain();

    do_flush();

    // Flush with valid_q=1 and busy={x3,x7}.
    send(32'h00000193, 32'h300, 5'd3, 32'd0, W);
    send(32'h00000393, 32'h304, 5'd7, 32'd0, W);
    send(32'h007184B3, 32'h308, 5'd9, 32'd0, W);
    idle();
    chk("busy37_stall", valid_o, 0);
    do_flush();
    send(32'h007184B3, 32'h30C, 5'd9, 32'd0, W);
    idle();
    chk("flush_busy_clear", valid_o, 1);
    drain();

    // RV32E: rd x17 is illegal and does not write.
    send(32'h002088B3, 32'h400, 5'd17, 32'd0, IL);
    idle();
    chk("x17_illegal", illegal_o, 1);
    chk("x17_wen", wen_o, 0);
    drain();

    // Reset mid-stall behaves like flush.
    send(32'h00000193, 32'h500, 5'd3, 32'd0, W);
    send(32'h007184B3, 32'h504, 5'd9, 32'd0, W);
    idle();
    chk("pre_rst_stall", valid_o, 0);
    @(negedge clk);
    rst = 0;
    q.delete();
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_pc", pc_o, 0);
    send(32'h007184B3, 32'h508, 5'd9, 32'd0, W);
    idle();
    chk("rst_busy_clear", valid_o, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_idu.md
Name: ysyx_idu

Overview:
- Instruction decode stage, directly downstream of the instruction fetch unit.
- Accepts {inst, pc} over a valid/ready handshake and holds it in a one-entry pipeline register.
- Decodes RV32 base-integer fields and immediates, and tracks register RAW hazards with a busy-bit scoreboard.
- Issues decoded packets to the execute unit over a second valid/ready handshake. Supports pipeline flush.

Parameters:
ADDR_W, 32, pc width
DATA_W, 32, instruction/immediate width
REG_NUM, 16, architectural registers (16 = RV32E, 32 = RV32I)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
prev_valid  in  1  upstream packet valid
ready_o  out  1  IDU can accept a packet this cycle
inst  in  DATA_W  instruction from fetch
pc  in  ADDR_W  pc of inst
next_ready  in  1  execute unit accepts this cycle
valid_o  out  1  decoded packet valid and hazard-free
pc_o  out  ADDR_W  registered pc
rs1_o, rs2_o, rd_o  out  5 each  register indices
imm_o  out  DATA_W  sign-extended immediate
opcode_o  out  7  raw opcode
funct3_o  out  3  raw funct3
funct7_o  out  7  raw funct7
wen_o  out  1  instruction writes rd (rd != 0)
is_load_o, is_store_o, is_branch_o, is_jal_o, is_jalr_o, is_system_o  out  1 each  class flags
illegal_o  out  1  undecodable opcode or register index >= REG_NUM
wb_valid  in  1  writeback retires a register
wb_rd  in  5  retired register index
flush  in  1  squash held packet and clear scoreboard

Behaviour:
- Reset (rst == 0 at posedge): valid register = 0, all busy bits = 0, all registered outputs = 0. ready_o = 1 in the first cycle after reset.
- Pipeline register state: valid_q plus the latched inst/pc. Decode is combinational from the latched inst, so outputs appear the cycle after acceptance (1-cycle latency).
- Hazard:
  - hz = valid_q & ((uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2])).
  - Before the check, busy is masked by the current-cycle writeback (wb_valid & wb_rd), which acts as a same-cycle bypass.
  - Register x0 is never busy.
- valid_o = valid_q & !hz & !flush.
- ready_o = !valid_q | (valid_o & next_ready). Accept when prev_valid & ready_o; a simultaneous issue and accept is allowed, giving a throughput of 1/cycle.
- Issue fires when valid_o & next_ready:
  - sets busy[rd] if wen_o;
  - clears valid_q unless a new packet is accepted in the same cycle.
- Writeback clears busy[wb_rd] when wb_valid. If issue sets and writeback clears the same register in the same cycle, set wins.
- Flush has priority over everything:
  - valid_q <= 0; all busy bits <= 0.
  - No accept and no issue that cycle; ready_o is forced to 0.
  - The execute side guarantees no other outstanding writebacks when flush is raised.
- Immediate formats (sign bit is inst[31]):
  - I (OP-IMM, LOAD, JALR, SYSTEM)
  - S (STORE)
  - B (BRANCH, bit0 = 0)
  - U (LUI, AUIPC, low 12 bits = 0)
  - J (JAL, bit0 = 0)
  - R-type and illegal encodings give imm = 0.
- uses_rs1 for I/S/B/R classes; uses_rs2 for S/B/R classes.
- wen_o = 1 for R, I (non-system), U, J, JALR classes when rd != 0.
- illegal_o:
  - set for an unknown opcode, or when inst[1:0] != 2'b11;
  - set when REG_NUM == 16 and any used register index has bit 4 set.
  - An illegal packet still issues with wen_o = 0 and no scoreboard effect; the execute unit raises the exception.
- Upstream must hold inst/pc stable while prev_valid & !ready_o. The IDU holds all outputs stable while valid_o & !next_ready.

Decomposition:
- Shared package/macro header: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM), immediate-format enum, and the handshake state encoding already used by the bus FSM macro.
- One natural sub-module: ysyx_idu_scoreboard. It holds the REG_NUM busy bits and has set, clear, flush and two combinational query ports.

Test Plan:
- Back-to-back independent ADDI x1/x2/x3 with next_ready = 1 -> valid_o every cycle after the first, throughput 1/cycle, imm_o = 0x00000005 for "addi x1,x0,5".
- "addi x1,x0,1" then "add x2,x1,x1" with no writeback -> second packet holds valid_o = 0 and ready_o = 0. With wb_valid = 1, wb_rd = 1 in cycle N, valid_o = 1 in cycle N (bypass).
- Issue of "lw x5,0(x6)" in the same cycle as wb_valid on x5 -> busy[5] remains 1 (set wins).
- "beq x1,x2,-4" (inst 0xFE208EE3) -> imm_o = 0xFFFFFFFC, is_branch_o = 1, wen_o = 0. "jal x1,2048" -> imm_o = 0x00000800.
- REG_NUM = 16 with "add x17,x1,x2" -> illegal_o = 1, wen_o = 0. Opcode 0x00 -> illegal_o = 1.
- flush asserted while valid_q = 1 and busy = {x3, x7} -> next cycle valid_o = 0, all busy = 0, ready_o = 1. rst = 0 mid-stall gives the same result.
